gpstb_sampler: RTL and testbench

- Wishbone-master sequencer that drains the GPS clock test-bench status registers once per local PPS.
- On each trigger it reads registers 1..7 in order. Reading register 1 freezes the test bench's capture; reading register 7 releases it.
- Each word is forwarded on a valid/ready stream to the debug/scope logic.
- It sits between the local PPS source and the GPS clock test bench's Wishbone slave port.

---
 rtl/gpstb_sampler_pkg.sv | 25 ++
 rtl/gpstb_sampler_if.sv | 26 ++
 rtl/gpstb_sampler_sat_counter.sv | 22 ++
 rtl/gpstb_sampler.sv | 145 ++++++++++++++
 tb/tb_gpstb_sampler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpstb_sampler_pkg.sv
// Shared definitions for the GPS clock test-bench status sampler.
//   state_t            : sequencer states
//   GPSTB_ADDR_FIRST/LAST   : first and last status register read per record
//   GPSTB_ADDR_HALT/RELEASE : registers whose read freezes / releases the
//                             test bench's capture
//   is_release()       : true for the register that closes a record
package gpsclk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      PUSH
   } state_t;

   localparam logic [2:0] GPSTB_ADDR_FIRST   = 3'd1;
   localparam logic [2:0] GPSTB_ADDR_LAST    = 3'd7;
   localparam logic [2:0] GPSTB_ADDR_HALT    = 3'd1;
   localparam logic [2:0] GPSTB_ADDR_RELEASE = 3'd7;

   function automatic logic is_release(input logic [2:0] addr);
      return addr == GPSTB_ADDR_RELEASE;
   endfunction

endpackage

// File: rtl/gpstb_sampler_if.sv
// Wishbone link between the sampler (master) and the GPS clock test bench
// status port (slave). Signal names are as seen from the master side.
//   o_wb_cyc/stb/we/addr/data : master -> slave request
//   i_wb_ack/stall/data       : slave -> master response
interface gpstb_sampler_if #(
   parameter int DW = 32
);
   logic          o_wb_cyc;
   logic          o_wb_stb;
   logic          o_wb_we;
   logic [2:0]    o_wb_addr;
   logic [DW-1:0] o_wb_data;
   logic          i_wb_ack;
   logic          i_wb_stall;
   logic [DW-1:0] i_wb_data;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      input  i_wb_ack, i_wb_stall, i_wb_data
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      output i_wb_ack, i_wb_stall, i_wb_data
   );
endinterface

// File: rtl/gpstb_sampler_sat_counter.sv
// Saturating up-counter.
//   i_clk, i_areset_n : clock, asynchronous active-low reset
//   i_inc             : count one event this cycle
//   o_count           : event count, sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_areset_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         o_count <= '0;
      end else if (i_inc && (o_count != {W{1'b1}})) begin
         o_count <= o_count + 1'b1;
      end
   end

endmodule

// File: rtl/gpstb_sampler.sv
// Wishbone-master sequencer that drains the GPS clock test-bench status
// registers 1..7 once per local PPS and forwards each word on a
// valid/ready stream. Reading register 1 freezes the test bench's
// capture, reading register 7 releases it.
//   i_clk, i_areset_n : clock, asynchronous active-low reset
//   i_trigger         : one-cycle PPS pulse starting a record
//   i_enable          : gate for new triggers
//   wb                : Wishbone master port (cyc held for the whole record)
//   o_valid/o_data/o_idx/o_last, i_ready : output stream, o_last on idx 7
//   o_busy            : record in progress
//   o_abort           : one-cycle pulse when an ack never arrives
//   o_overrun         : saturating count of triggers dropped while busy
module gpstb_sampler
   import gpsclk_pkg::*;
#(
   parameter int DW      = 32,
   parameter int TIMEOUT = 15,   // must be >= 1
   parameter int OVW     = 8
) (
   input  logic            i_clk,
   input  logic            i_areset_n,
   input  logic            i_trigger,
   input  logic            i_enable,
   gpstb_sampler_if.master wb,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic [2:0]      o_idx,
   output logic            o_last,
   input  logic            i_ready,
   output logic            o_busy,
   output logic            o_abort,
   output logic [OVW-1:0]  o_overrun
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

   state_t        state;
   logic [2:0]    addr;
   logic [TW-1:0] tmo_cnt;
   logic          start;
   logic          drop;

   // Enabled triggers start a record only from IDLE; any other enabled
   // trigger (including one coincident with the final accept) is dropped.
   assign start = i_trigger && i_enable && (state == IDLE);
   assign drop  = i_trigger && i_enable && (state != IDLE);

   assign wb.o_wb_we   = 1'b0;
   assign wb.o_wb_data = '0;

   // NOTE: every register below is assigned with <= so all of them update
   // from the same pre-edge values; mixing in = would make the result
   // depend on statement order.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state        <= IDLE;
         addr         <= GPSTB_ADDR_FIRST;
         tmo_cnt      <= '0;
         wb.o_wb_cyc  <= 1'b0;
         wb.o_wb_stb  <= 1'b0;
         wb.o_wb_addr <= '0;
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_idx        <= '0;
         o_last       <= 1'b0;
         o_busy       <= 1'b0;
         o_abort      <= 1'b0;
      end else begin
         o_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // First read freezes the test bench capture.
                  addr         <= GPSTB_ADDR_HALT;
                  wb.o_wb_addr <= GPSTB_ADDR_HALT;
                  wb.o_wb_cyc  <= 1'b1;
                  wb.o_wb_stb  <= 1'b1;
                  o_busy       <= 1'b1;
                  state        <= REQ;
               end
            end

            REQ: begin
               // stb is always high here, so acceptance is just !stall.
               if (!wb.i_wb_stall) begin
                  wb.o_wb_stb <= 1'b0;
                  tmo_cnt     <= TMO_LOAD;
                  state       <= WAIT;
               end
            end

            WAIT: begin
               if (wb.i_wb_ack) begin
                  o_data  <= wb.i_wb_data;
                  o_idx   <= addr;
                  o_last  <= is_release(addr);
                  o_valid <= 1'b1;
                  state   <= PUSH;
               end else if (tmo_cnt == TW'(1)) begin
                  // Counter would reach zero: TIMEOUT cycles after
                  // acceptance have passed without an ack.
                  wb.o_wb_cyc <= 1'b0;
                  o_abort     <= 1'b1;
                  o_busy      <= 1'b0;
                  addr        <= GPSTB_ADDR_FIRST;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end

            PUSH: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
                  if (addr == GPSTB_ADDR_LAST) begin
                     wb.o_wb_cyc <= 1'b0;
                     o_busy      <= 1'b0;
                     addr        <= GPSTB_ADDR_FIRST;
                     state       <= IDLE;
                  end else begin
                     addr         <= addr + 3'd1;
                     wb.o_wb_addr <= addr + 3'd1;
                     wb.o_wb_stb  <= 1'b1;
                     state        <= REQ;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(
      .W (OVW)
   ) u_overrun (
      .i_clk      (i_clk),
      .i_areset_n (i_areset_n),
      .i_inc      (drop),
      .o_count    (o_overrun)
   );

endmodule

// File: tb/tb_gpstb_sampler.sv
`timescale 1ns/1ps
module tb_gpstb_sampler;

   localparam int DW      = 32;
   localparam int TIMEOUT = 15;
   localparam int OVW     = 8;
   localparam int OV_MAX  = (1 << OVW) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           trigger = 1'b0;
   logic           enable = 1'b0;
   logic           ready = 1'b0;
   logic           valid;
   logic [DW-1:0]  data;
   logic [2:0]     idx;
   logic           last;
   logic           busy;
   logic           abort;
   logic [OVW-1:0] overrun;

   gpstb_sampler_if #(.DW(DW)) wb ();

   gpstb_sampler #(
      .DW      (DW),
      .TIMEOUT (TIMEOUT),
      .OVW     (OVW)
   ) dut (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .i_trigger  (trigger),
      .i_enable   (enable),
      .wb         (wb),
      .o_valid    (valid),
      .o_data     (data),
      .o_idx      (idx),
      .o_last     (last),
      .i_ready    (ready),
      .o_busy     (busy),
      .o_abort    (abort),
      .o_overrun  (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model -------------------------------------
   bit            pend = 0;
   logic [2:0]    paddr;
   int            pdly;
   int            noack_addr = 0;
   int            slow_addr = 0;
   int            slow_dly = 0;
   bit            rnd_slave = 0;
   logic [DW-1:0] data_base = 32'hA0;

   // ---------------- reference model (random phase) ------------------
   bit            model_on = 0;
   bit            m_busy;
   logic [2:0]    m_idx;
   int            m_ov;

   // Advance one clock. Inputs set during the current cycle are consumed
   // at the coming edge; outputs are sampled 1 ns after it.
   task automatic step();
      bit take, m_trig, m_acc, was_busy;
      take   = wb.o_wb_stb && !wb.i_wb_stall;
      m_trig = trigger && enable;
      m_acc  = valid && ready;
      if (take) begin
         pend  = 1;
         paddr = wb.o_wb_addr;
         if (rnd_slave)                     pdly = $urandom_range(0, 4);
         else if (int'(paddr) == slow_addr) pdly = slow_dly;
         else                               pdly = 0;
         if (int'(paddr) == noack_addr) pend = 0;
      end
      @(posedge clk);
      #1;
      wb.i_wb_ack = 1'b0;
      if (pend) begin
         if (pdly == 0) begin
            wb.i_wb_ack  = 1'b1;
            wb.i_wb_data = data_base + DW'(paddr);
            pend = 0;
         end else begin
            pdly--;
         end
      end
      if (model_on) begin
         // A record is a trigger accepted while idle plus seven accepted
         // words; enabled triggers in between are overruns.
         was_busy = m_busy;
         if (m_trig) begin
            if (m_busy) begin
               if (m_ov < OV_MAX) m_ov++;
            end else begin
               m_busy    = 1;
               m_idx     = 3'd1;
               data_base = $urandom;
            end
         end
         if (m_acc && was_busy) begin
            if (m_idx == 3'd7) m_busy = 0;
            else               m_idx  = m_idx + 3'd1;
         end
      end
   endtask

   task automatic idle(input int n);
      trigger = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- single-record runner ----------------------------
   int            r_words, r_end, r_abort_t, r_acc5_t, r_stb3, r_first_addr;
   int            r_bp_acc_t, r_after_bp_t, r_after_bp_addr;
   bit            r_bp_ok, r_abort_cyc;
   logic [2:0]    r_idx  [8];
   logic [DW-1:0] r_data [8];
   logic          r_last [8];

   task automatic run_record(input int stall_addr, input int stall_len, input int bp_idx,
                             input int bp_len, input bit extra_trig, input bit en_drop);
      int            stall_used, bp_used;
      bit            seen_busy;
      logic [DW-1:0] hold_d;
      logic [2:0]    hold_i;
      stall_used = 0; bp_used = 0; seen_busy = 0;
      hold_d = '0; hold_i = '0;
      r_words = 0; r_end = -1; r_abort_t = -1; r_acc5_t = -1; r_stb3 = 0;
      r_first_addr = -1; r_bp_acc_t = -1; r_after_bp_t = -1; r_after_bp_addr = -1;
      r_bp_ok = 1; r_abort_cyc = 1;
      for (int t = 0; t < 100; t++) begin
         enable  = en_drop ? (t == 0) : 1'b1;
         trigger = (t == 0) || (extra_trig && (t == 3 || t == 6 || t == 9));
         wb.i_wb_stall = wb.o_wb_stb && (int'(wb.o_wb_addr) == stall_addr) && (stall_used < stall_len);
         if (wb.i_wb_stall) stall_used++;
         ready = !(valid && int'(idx) == bp_idx && bp_used < bp_len);
         if (!ready) begin
            if (bp_used == 0) begin
               hold_d = data;
               hold_i = idx;
            end else if (data !== hold_d || idx !== hold_i) begin
               r_bp_ok = 0;
            end
            if (wb.o_wb_stb || !wb.o_wb_cyc) r_bp_ok = 0;
            // Ack while not waiting for one must be ignored.
            wb.i_wb_ack  = 1'b1;
            wb.i_wb_data = 32'hDEAD_BEEF;
            bp_used++;
         end
         if (wb.o_wb_stb && r_first_addr < 0) r_first_addr = int'(wb.o_wb_addr);
         if (wb.o_wb_stb && wb.o_wb_addr == 3'd3) r_stb3++;
         if (wb.o_wb_stb && !wb.i_wb_stall && wb.o_wb_addr == 3'd5) r_acc5_t = t;
         if (r_bp_acc_t >= 0 && r_after_bp_t < 0 && wb.o_wb_stb) begin
            r_after_bp_t    = t;
            r_after_bp_addr = int'(wb.o_wb_addr);
         end
         if (valid && ready) begin
            if (bp_len > 0 && int'(idx) == bp_idx) r_bp_acc_t = t;
            if (r_words < 8) begin
               r_idx[r_words]  = idx;
               r_data[r_words] = data;
               r_last[r_words] = last;
               r_words++;
            end
         end
         if (abort) begin
            r_abort_t   = t;
            r_abort_cyc = wb.o_wb_cyc;
         end
         if (busy) begin
            seen_busy = 1;
         end else if (seen_busy) begin
            r_end = t;
            break;
         end
         step();
      end
      trigger = 0; enable = 1; ready = 1; wb.i_wb_stall = 0;
   endtask

   task automatic check_words(input string name, input int n);
      check({name, "_count"}, r_words, n);
      for (int i = 0; i < n && i < r_words; i++)
         check($sformatf("%s_w%0d", name, i), {r_idx[i], r_last[i], r_data[i]},
               {3'(i + 1), (i == 6), data_base + DW'(i + 1)});
   endtask

   // ---------------- basic-record vector table -----------------------
   typedef struct {
      bit            trig;
      bit            stb;
      logic [2:0]    addr;
      bit            vld;
      logic [2:0]    idx;
      logic [DW-1:0] d;
      bit            lst;
      bit            bsy;
   } vec_t;

   vec_t tbl [33];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      wb.i_wb_ack = 0; wb.i_wb_stall = 0; wb.i_wb_data = '0;

      // Trigger in cycle 10: stb every 3 cycles from 11, words every 3
      // cycles from 13, busy through cycle 31.
      for (int t = 0; t < 33; t++) begin
         tbl[t].trig = (t == 10);
         tbl[t].stb  = (t >= 11 && t <= 29 && (t - 11) % 3 == 0);
         tbl[t].addr = tbl[t].stb ? 3'((t - 11) / 3 + 1) : 3'd0;
         tbl[t].vld  = (t >= 13 && t <= 31 && (t - 13) % 3 == 0);
         tbl[t].idx  = tbl[t].vld ? 3'((t - 13) / 3 + 1) : 3'd0;
         tbl[t].d    = tbl[t].vld ? 32'hA0 + DW'(tbl[t].idx) : '0;
         tbl[t].lst  = tbl[t].vld && tbl[t].idx == 3'd7;
         tbl[t].bsy  = (t >= 11 && t <= 31);
      end

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #2;
      check("rst_cyc",     wb.o_wb_cyc, 0);
      check("rst_stb",     wb.o_wb_stb, 0);
      check("rst_we",      wb.o_wb_we, 0);
      check("rst_addr",    wb.o_wb_addr, 0);
      check("rst_wdata",   wb.o_wb_data, 0);
      check("rst_valid",   valid, 0);
      check("rst_data",    data, 0);
      check("rst_idx",     idx, 0);
      check("rst_last",    last, 0);
      check("rst_busy",    busy, 0);
      check("rst_abort",   abort, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1;
      enable = 1; ready = 1;
      step();

      // ---- basic record, cycle-exact ----
      for (int t = 0; t < 33; t++) begin
         trigger = tbl[t].trig;
         check($sformatf("basic_t%0d", t),
               {wb.o_wb_stb, wb.o_wb_stb ? wb.o_wb_addr : 3'd0, valid, valid ? idx : 3'd0,
                valid ? data : 32'd0, valid & last, busy, wb.o_wb_cyc, wb.o_wb_we, abort},
               {tbl[t].stb, tbl[t].addr, tbl[t].vld, tbl[t].idx, tbl[t].d, tbl[t].lst,
                tbl[t].bsy, tbl[t].bsy, 1'b0, 1'b0});
         step();
      end
      idle(3);

      // ---- stall on the addr-3 request ----
      run_record(3, 4, 0, 0, 0, 0);
      check("stall_stb3_cycles", r_stb3, 5);
      check_words("stall", 7);
      check("stall_end", r_end, 26);
      idle(3);

      // ---- backpressure on idx 2, with a stray ack while pushing ----
      run_record(0, 0, 2, 6, 0, 0);
      check("bp_stable", r_bp_ok, 1);
      check("bp_next_req_delay", r_after_bp_t - r_bp_acc_t, 1);
      check("bp_next_req_addr", r_after_bp_addr, 3);
      check_words("bp", 7);
      check("bp_end", r_end, 28);
      idle(3);

      // ---- timeout on addr 5 ----
      // Ack is still honoured 15 cycles after acceptance, so the abort
      // pulse appears on the following cycle.
      noack_addr = 5;
      run_record(0, 0, 0, 0, 0, 0);
      check_words("tmo", 4);
      check("tmo_abort_latency", r_abort_t - r_acc5_t, TIMEOUT + 1);
      check("tmo_abort_cyc", r_abort_cyc, 0);
      check("tmo_end", r_end, r_abort_t);
      step();
      check("tmo_abort_width", abort, 0);
      noack_addr = 0;
      idle(3);

      // ---- latest permitted ack (15 cycles after acceptance) ----
      slow_addr = 5; slow_dly = TIMEOUT - 1;
      run_record(0, 0, 0, 0, 0, 0);
      check("slow_ok_abort", r_abort_t, -1);
      check_words("slow_ok", 7);
      check("slow_ok_end", r_end, 22 + TIMEOUT - 1);
      idle(3);

      // ---- one cycle too late: abort, late ack lands in IDLE ----
      slow_dly = TIMEOUT;
      run_record(0, 0, 0, 0, 0, 0);
      check_words("late", 4);
      check("late_abort_latency", r_abort_t - r_acc5_t, TIMEOUT + 1);
      slow_addr = 0; slow_dly = 0;
      idle(4);
      check("late_idle_busy", busy, 0);

      // ---- restart after abort ----
      run_record(0, 0, 0, 0, 0, 0);
      check("restart_first_addr", r_first_addr, 1);
      check_words("restart", 7);
      check("restart_end", r_end, 22);
      idle(3);

      // ---- enable dropped mid-record ----
      run_record(0, 0, 0, 0, 0, 1);
      check_words("endrop", 7);
      check("endrop_end", r_end, 22);
      idle(3);

      // ---- overrun: three triggers during a record ----
      run_record(0, 0, 0, 0, 1, 0);
      check_words("ovr", 7);
      check("ovr_end", r_end, 22);
      check("ovr_count", overrun, 3);

      // ---- triggers with enable low are ignored ----
      enable = 0; trigger = 1;
      for (int i = 0; i < 20; i++) step();
      trigger = 0;
      check("en_low_busy", busy, 0);
      check("en_low_overrun", overrun, 3);
      enable = 1;

      // ---- saturation ----
      trigger = 1;
      for (int i = 0; i < 400; i++) step();
      trigger = 0;
      check("sat_overrun", overrun, OV_MAX);
      found = 0;
      for (int i = 0; i < 60; i++) begin
         if (!busy) begin
            found = 1;
            break;
         end
         step();
      end
      check("sat_drain", found, 1);
      check("sat_hold", overrun, OV_MAX);

      // ---- asynchronous reset during WAIT at addr 4 ----
      noack_addr = 4;
      trigger = 1; step(); trigger = 0;
      found = 0;
      for (int i = 0; i < 60; i++) begin
         if (wb.o_wb_stb && wb.o_wb_addr == 3'd4) begin
            found = 1;
            break;
         end
         step();
      end
      check("arst_reach_addr4", found, 1);
      step(); step();
      check("arst_pre_cyc", wb.o_wb_cyc, 1);
      #2;
      rst_n = 0;
      #1;
      check("arst_cyc",     wb.o_wb_cyc, 0);
      check("arst_stb",     wb.o_wb_stb, 0);
      check("arst_valid",   valid, 0);
      check("arst_busy",    busy, 0);
      check("arst_overrun", overrun, 0);
      noack_addr = 0; pend = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1;
      step();
      check("post_rst_busy",    busy, 0);
      check("post_rst_cyc",     wb.o_wb_cyc, 0);
      check("post_rst_addr",    wb.o_wb_addr, 0);
      check("post_rst_overrun", overrun, 0);

      // ---- randomized traffic against the record-level model ----
      m_busy = 0; m_idx = 3'd1; m_ov = 0;
      rnd_slave = 1; model_on = 1;
      for (int c = 0; c < 2500; c++) begin
         trigger       = ($urandom_range(0, 24) == 0);
         enable        = ($urandom_range(0, 4) != 0);
         wb.i_wb_stall = ($urandom_range(0, 3) == 0);
         ready         = ($urandom_range(0, 9) < 7);
         check("rnd_busy",    busy, m_busy);
         check("rnd_cyc",     wb.o_wb_cyc, m_busy);
         check("rnd_overrun", overrun, m_ov);
         check("rnd_abort",   abort, 0);
         if (valid && ready)
            check("rnd_word", {idx, last, data}, {m_idx, m_idx == 3'd7, data_base + DW'(m_idx)});
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
